// File: rtl/dense_out_layer_if.sv
// rtl/dense_out_layer_if.sv - activation stream, weight ROM, bias and score bundle for dense_out_layer
interface dense_out_layer_if #(
    parameter int N_OUT  = 10,
    parameter int DATA_W = 8,
    parameter int BIAS_W = 16,
    parameter int ADDR_W = 8
);
    logic                      start;
    logic                      act_valid;
    logic [DATA_W-1:0]         act_data;
    logic                      act_ready;
    logic [N_OUT*BIAS_W-1:0]   bias_data;
    logic [ADDR_W-1:0]         w_addr;
    logic [N_OUT*DATA_W-1:0]   w_data;
    logic [N_OUT*DATA_W-1:0]   dens_out;
    logic                      done;

    modport master (
        output start, act_valid, act_data, bias_data, w_data,
        input  act_ready, w_addr, dens_out, done
    );

    modport slave (
        input  start, act_valid, act_data, bias_data, w_data,
        output act_ready, w_addr, dens_out, done
    );
endinterface

// File: rtl/dense_out_layer.sv
// rtl/dense_out_layer.sv - final fully-connected layer: N_OUT parallel int8 MACs, bias, round/saturate to int8
module dense_out_layer #(
    parameter int N_IN   = 196,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 8,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 8,
    parameter int ADDR_W = 8
) (
    input logic              clk,
    input logic              rst,
    dense_out_layer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, REQ} state_t;

    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2**(SHIFT-1));
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2**(DATA_W-1)-1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2**(DATA_W-1)));
    localparam logic [ADDR_W-1:0]       LAST = ADDR_W'(N_IN-1);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        cnt;
    logic signed [DATA_W-1:0] act_q;
    logic                     mac_v;
    logic signed [ACC_W-1:0]  acc [N_OUT];
    logic signed [ACC_W-1:0]  shf [N_OUT];
    logic [N_OUT*DATA_W-1:0]  dens_q, dens_nxt;
    logic                     done_q;
    logic                     accept;

    assign accept        = bus.act_valid && (state == ACC);
    assign bus.act_ready = (state == ACC);
    assign bus.w_addr    = cnt;
    assign bus.dens_out  = dens_q;
    assign bus.done      = done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ACC;
            ACC:     if (accept && cnt == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = REQ;
            REQ:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Round-half-up then arithmetic shift; saturate the result to the int8 range
    always_comb begin
        dens_nxt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            shf[k] = (acc[k] + RND) >>> SHIFT;
            if (shf[k] > SMAX)
                dens_nxt[k*DATA_W +: DATA_W] = SMAX[DATA_W-1:0];
            else if (shf[k] < SMIN)
                dens_nxt[k*DATA_W +: DATA_W] = SMIN[DATA_W-1:0];
            else
                dens_nxt[k*DATA_W +: DATA_W] = shf[k][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            act_q  <= '0;
            mac_v  <= 1'b0;
            dens_q <= '0;
            done_q <= 1'b0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
        end else begin
            state  <= state_nxt;
            mac_v  <= 1'b0;
            done_q <= 1'b0;
            if (state == IDLE && bus.start) begin
                cnt <= '0;
                for (int k = 0; k < N_OUT; k++)
                    acc[k] <= {{(ACC_W-BIAS_W){bus.bias_data[k*BIAS_W+BIAS_W-1]}},
                               bus.bias_data[k*BIAS_W +: BIAS_W]};
            end
            if (accept) begin
                act_q <= bus.act_data;
                mac_v <= 1'b1;
                cnt   <= cnt + 1'b1;
            end
            // w_data now carries the ROM row addressed during the accept cycle
            if (mac_v) begin
                for (int k = 0; k < N_OUT; k++)
                    acc[k] <= acc[k] + ACC_W'(act_q * $signed(bus.w_data[k*DATA_W +: DATA_W]));
            end
            if (state == REQ) begin
                dens_q <= dens_nxt;
                done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dense_out_layer.sv
// tb/tb_dense_out_layer.sv - scoreboard bench for dense_out_layer
module tb_dense_out_layer;
    localparam int N_IN = 196, N_OUT = 10, DATA_W = 8, BIAS_W = 16, ADDR_W = 8;
    localparam int DW = N_OUT*DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dense_out_layer_if #(.N_OUT(N_OUT), .DATA_W(DATA_W), .BIAS_W(BIAS_W), .ADDR_W(ADDR_W)) bus ();

    dense_out_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .BIAS_W(BIAS_W),
                      .ACC_W(24), .SHIFT(8), .ADDR_W(ADDR_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0]            rom [256];
    logic signed [DATA_W-1:0] acts [N_IN];

    always @(posedge clk) bus.w_data <= rom[bus.w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] dens; int cyc; } exp_t;
    exp_t sbq[$];
    int errors = 0, checks = 0, dones = 0, pushed = 0;

    task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack_w(input int base, input int step);
        logic [DW-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k*DATA_W +: DATA_W] = 8'(base + step*k);
        return r;
    endfunction

    function automatic logic [N_OUT*BIAS_W-1:0] pack_b(input int step);
        logic [N_OUT*BIAS_W-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k*BIAS_W +: BIAS_W] = 16'(step*k);
        return r;
    endfunction

    function automatic logic [DW-1:0] pack_list(input int v [N_OUT]);
        logic [DW-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k*DATA_W +: DATA_W] = 8'(v[k]);
        return r;
    endfunction

    task automatic rom_fill(input logic [DW-1:0] row);
        for (int i = 0; i < 256; i++) rom[i] = row;
    endtask

    task automatic acts_fill(input int v, input int n);
        for (int i = 0; i < N_IN; i++) acts[i] = (i < n) ? 8'(v) : 8'sd0;
    endtask

    // Monitor: pops the scoreboard on every done and checks stability of dens_out otherwise
    logic [DW-1:0] prev_dens = '0;
    logic rst_d = 1'b1, done_d = 1'b0;
    always @(negedge clk) begin
        if (!rst && !rst_d) begin
            if (bus.done) begin
                exp_t e;
                dones++;
                chk("done_not_back_to_back", 32'(done_d), 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    for (int k = 0; k < N_OUT; k++)
                        chk($sformatf("dens[%0d]", k), 32'($signed(bus.dens_out[k*DATA_W +: DATA_W])),
                            32'($signed(e.dens[k*DATA_W +: DATA_W])));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else begin
                checks++;
                if (bus.dens_out !== prev_dens) begin
                    errors++;
                    $display("FAIL dens_stable: got %h expected %h (cycle %0d)", bus.dens_out, prev_dens, cyc);
                end
            end
        end
        prev_dens = bus.dens_out;
        rst_d     = rst;
        done_d    = bus.done;
    end

    task automatic reset_checks();
        @(negedge clk);
        chk("rst_dens_out", 32'(bus.dens_out != '0), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_act_ready", 32'(bus.act_ready), 0);
        chk("rst_w_addr", 32'(bus.w_addr), 0);
    endtask

    task automatic run(input logic [N_OUT*BIAS_W-1:0] bias, input bit stall, input int start_at,
                       input int rst_after, input logic [DW-1:0] exp_d);
        int idx = 0, guard = 0, last = 0;
        bit acc_now;
        exp_t e;
        @(posedge clk); #1;
        bus.bias_data = bias;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (idx < N_IN && guard < 2000) begin
            bus.act_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.act_data  = acts[idx];
            bus.start     = (idx == start_at);
            @(negedge clk);
            chk("w_addr_tracks_accepts", 32'(bus.w_addr), idx);
            chk("act_ready_in_acc", 32'(bus.act_ready), 1);
            acc_now = bus.act_valid && bus.act_ready;
            if (acc_now) last = cyc;
            @(posedge clk); #1;
            if (acc_now) idx++;
            guard++;
            if (rst_after >= 0 && idx == rst_after) begin
                rst = 1'b1;
                bus.act_valid = 1'b0;
                bus.start = 1'b0;
                repeat (2) @(posedge clk);
                reset_checks();
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
        bus.start     = 1'b0;
        bus.act_valid = 1'b1;
        bus.act_data  = -8'sd128;
        if (idx < N_IN) begin
            chk("feed_timeout", idx, N_IN);
        end else begin
            e.dens = exp_d;
            e.cyc  = last + 3;
            sbq.push_back(e);
            pushed++;
            @(negedge clk);
            chk("act_ready_drops", 32'(bus.act_ready), 0);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (sbq.size() != 0 && g < 20) begin
            @(posedge clk);
            g++;
        end
        if (sbq.size() != 0) chk("done_timeout", sbq.size(), 0);
        bus.act_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int mixed_exp [N_OUT] = '{-8, -5, -3, 0, 2, 5, 8, 10, 13, 15};
    int addr_exp  [N_OUT] = '{0, 4, 8, 12, 16, 20, 23, 27, 31, 35};

    initial begin
        bus.start = 1'b0; bus.act_valid = 1'b0; bus.act_data = '0; bus.bias_data = '0;
        rom_fill('0);
        acts_fill(0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        reset_checks();
        @(posedge clk); #1;
        rst = 1'b0;

        acts_fill(1, 4); rom_fill(pack_w(96, 0));
        run(pack_b(0), 1'b0, -1, -1, pack_w(2, 0));    wait_idle();
        rom_fill(pack_w(-96, 0));
        run(pack_b(0), 1'b0, -1, -1, pack_w(-1, 0));   wait_idle();

        acts_fill(127, N_IN); rom_fill(pack_w(127, 0));
        run(pack_b(0), 1'b0, -1, -1, pack_w(127, 0));  wait_idle();
        rom_fill(pack_w(-128, 0));
        run(pack_b(0), 1'b0, -1, -1, pack_w(-128, 0)); wait_idle();

        rom_fill(pack_w(127, 0));
        run(pack_b(0), 1'b1, -1, -1, pack_w(127, 0));  wait_idle();
        rom_fill(pack_w(-128, 0));
        run(pack_b(0), 1'b1, -1, -1, pack_w(-128, 0)); wait_idle();

        acts_fill(2, N_IN); rom_fill(pack_w(-5, 1));
        run(pack_b(256), 1'b0, -1, -1, pack_list(mixed_exp)); wait_idle();

        acts_fill(0, 0); acts[100] = 8'sd100;
        rom_fill('0); rom[100] = pack_w(0, 10);
        run(pack_b(0), 1'b0, -1, -1, pack_list(addr_exp)); wait_idle();

        acts_fill(127, N_IN); rom_fill(pack_w(127, 0));
        run(pack_b(0), 1'b0, 50, -1, pack_w(127, 0));  wait_idle();
        run(pack_b(0), 1'b0, -1, 10, '0);
        run(pack_b(0), 1'b0, -1, -1, pack_w(127, 0));  wait_idle();

        repeat (5) @(posedge clk);
        chk("done_count", dones, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
